// File: rtl/jump_resolve_unit_pkg.sv
// ============================================================================
// Module      : jump_resolve_unit_pkg
// Description : Shared definitions for the branch/jump resolve unit.
//               Holds the compare-op encodings, which are cmp_ctrl[3:1] of
//               the issue bus, and the two-state sequencer encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jump_resolve_unit_pkg;

  // Compare-op encodings for cmp_ctrl[3:1]
  localparam logic [2:0] CMP_NONE   = 3'b000;  // never taken
  localparam logic [2:0] CMP_EQ     = 3'b001;
  localparam logic [2:0] CMP_NE     = 3'b010;
  localparam logic [2:0] CMP_LT     = 3'b011;  // signed
  localparam logic [2:0] CMP_LTU    = 3'b100;
  localparam logic [2:0] CMP_GE     = 3'b101;  // signed
  localparam logic [2:0] CMP_GEU    = 3'b110;
  localparam logic [2:0] CMP_ALWAYS = 3'b111;  // JAL

  // Sequencer states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } jru_state_t;

endpackage : jump_resolve_unit_pkg

`default_nettype wire

// File: rtl/add_32.sv
// ============================================================================
// Module      : add_32
// Description : 32-bit combinational adder. The carry-out is discarded, so
//               the sum wraps modulo 2^32.
// Ports       : i_a, i_b  - addends
//               o_c       - i_a + i_b (low 32 bits)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_c
);

  assign o_c = i_a + i_b;

endmodule : add_32

`default_nettype wire

// File: rtl/cmp_32.sv
// ============================================================================
// Module      : cmp_32
// Description : 32-bit combinational branch comparator. Evaluates the branch
//               condition selected by i_ctrl on the two source operands.
// Ports       : i_a, i_b  - operands (rs1, rs2)
//               i_ctrl    - compare op (CMP_* encodings)
//               o_c       - 1 when the condition holds
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_32
  import jump_resolve_unit_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [2:0]  i_ctrl,
  output logic        o_c
);

  logic w_eq;
  logic w_lt;
  logic w_ltu;

  assign w_eq  = (i_a == i_b);
  assign w_lt  = ($signed(i_a) < $signed(i_b));
  assign w_ltu = (i_a < i_b);

  always_comb begin
    o_c = 1'b0;
    case (i_ctrl)
      CMP_EQ:     o_c = w_eq;
      CMP_NE:     o_c = ~w_eq;
      CMP_LT:     o_c = w_lt;
      CMP_LTU:    o_c = w_ltu;
      CMP_GE:     o_c = ~w_lt;
      CMP_GEU:    o_c = ~w_ltu;
      CMP_ALWAYS: o_c = 1'b1;
      default:    o_c = 1'b0;  // CMP_NONE
    endcase
  end

endmodule : cmp_32

`default_nettype wire

// File: rtl/jump_resolve_unit.sv
// ============================================================================
// Module      : jump_resolve_unit
// Description : Two-cycle branch/JAL/JALR resolve unit. An op is captured on
//               an idle edge and its results are valid (o_finish high) for the
//               following cycle. All outputs derive only from the captured
//               operand registers, so they hold until the next accepted op.
// Ports       : clk          - rising-edge clock
//               rst          - asynchronous reset, active LOW
//               i_en         - issue strobe, accepted only while idle
//               i_jalr       - 1: target rs1+imm, 0: target pc+imm
//               i_cmp_ctrl   - [3:1] compare op, [0] unused
//               i_rs1_data   - source operand 1
//               i_rs2_data   - source operand 2
//               i_imm        - sign-extended immediate
//               i_pc         - instruction PC
//               o_pc_jump    - branch/jump target
//               o_pc_wb      - link value, pc + 4
//               o_is_jump    - control transfer taken
//               o_finish     - result valid, one cycle per accepted op
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jump_resolve_unit
  import jump_resolve_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_en,
  input  logic            i_jalr,
  input  logic [3:0]      i_cmp_ctrl,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_pc,
  output logic [XLEN-1:0] o_pc_jump,
  output logic [XLEN-1:0] o_pc_wb,
  output logic            o_is_jump,
  output logic            o_finish
);

  localparam logic [XLEN-1:0] C_LINK_OFFSET = XLEN'(4);

  jru_state_t      r_state;
  jru_state_t      w_state_nxt;
  logic            w_load;

  logic            r_jalr;
  logic [2:0]      r_cmp_op;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_pc;

  logic [XLEN-1:0] w_target_base;
  logic            w_cmp_res;

  // cmp_ctrl[0] carries no meaning for this unit
  logic            w_unused_cmp_lsb;
  assign w_unused_cmp_lsb = i_cmp_ctrl[0];

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    o_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_en) begin
          w_load      = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Result cycle: en is ignored, so an op can only start one cycle later
        o_finish    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_jalr   <= 1'b0;
      r_cmp_op <= CMP_NONE;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_imm    <= '0;
      r_pc     <= '0;
    end else if (w_load) begin
      r_jalr   <= i_jalr;
      r_cmp_op <= i_cmp_ctrl[3:1];
      r_rs1    <= i_rs1_data;
      r_rs2    <= i_rs2_data;
      r_imm    <= i_imm;
      r_pc     <= i_pc;
    end
  end

  // --------------------------------------------------------------------------
  // Result datapath
  // --------------------------------------------------------------------------
  assign w_target_base = r_jalr ? r_rs1 : r_pc;

  add_32 u_add_target (
    .i_a (w_target_base),
    .i_b (r_imm),
    .o_c (o_pc_jump)
  );

  add_32 u_add_link (
    .i_a (r_pc),
    .i_b (C_LINK_OFFSET),
    .o_c (o_pc_wb)
  );

  cmp_32 u_cmp (
    .i_a    (r_rs1),
    .i_b    (r_rs2),
    .i_ctrl (r_cmp_op),
    .o_c    (w_cmp_res)
  );

  // JALR always transfers control regardless of the compare op
  assign o_is_jump = r_jalr | w_cmp_res;

endmodule : jump_resolve_unit

`default_nettype wire

// File: tb/tb_jump_resolve_unit.sv
// ============================================================================
// Module      : tb_jump_resolve_unit
// Description : Self-checking bench for jump_resolve_unit. A transaction-level
//               reference model predicts the result of each accepted op and
//               the expected finish pulse; outputs are checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jump_resolve_unit;

  logic        clk;
  logic        rst;
  logic        i_en;
  logic        i_jalr;
  logic [3:0]  i_cmp_ctrl;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic [31:0] i_imm;
  logic [31:0] i_pc;
  logic [31:0] o_pc_jump;
  logic [31:0] o_pc_wb;
  logic        o_is_jump;
  logic        o_finish;

  int n_cmp;
  int n_mis;

  // Reference model state: last accepted op's results and whether the
  // current cycle is the result cycle.
  bit          m_fin;
  logic [31:0] m_pc_jump;
  logic [31:0] m_pc_wb;
  logic        m_is_jump;

  jump_resolve_unit #(.XLEN(32)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (i_en),
    .i_jalr     (i_jalr),
    .i_cmp_ctrl (i_cmp_ctrl),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .i_imm      (i_imm),
    .i_pc       (i_pc),
    .o_pc_jump  (o_pc_jump),
    .o_pc_wb    (o_pc_wb),
    .o_is_jump  (o_is_jump),
    .o_finish   (o_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Branch condition from the ISA definition of each op
  function automatic bit ref_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int signed sa;
    int signed sb;
    sa = a;
    sb = b;
    case (op)
      3'd1:    return a == b;
      3'd2:    return a != b;
      3'd3:    return sa < sb;
      3'd4:    return a < b;
      3'd5:    return sa >= sb;
      3'd6:    return a >= b;
      3'd7:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_fin     = 1'b0;
    m_pc_jump = 32'h0;
    m_pc_wb   = 32'h4;
    m_is_jump = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".finish"},  {31'b0, o_finish},  {31'b0, m_fin});
    check({tag, ".is_jump"}, {31'b0, o_is_jump}, {31'b0, m_is_jump});
    check({tag, ".pc_jump"}, o_pc_jump, m_pc_jump);
    check({tag, ".pc_wb"},   o_pc_wb,   m_pc_wb);
  endtask

  task automatic drive(input bit en, input bit jalr, input logic [3:0] ctrl,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [31:0] pc);
    i_en       = en;
    i_jalr     = jalr;
    i_cmp_ctrl = ctrl;
    i_rs1_data = rs1;
    i_rs2_data = rs2;
    i_imm      = imm;
    i_pc       = pc;
  endtask

  // Advance one clock edge and update the model; caller is at a negedge.
  task automatic step();
    bit accept;
    accept = !m_fin && i_en;
    if (accept) begin
      m_pc_jump = (i_jalr ? i_rs1_data : i_pc) + i_imm;
      m_pc_wb   = i_pc + 32'd4;
      m_is_jump = i_jalr | ref_taken(i_cmp_ctrl[3:1], i_rs1_data, i_rs2_data);
    end
    m_fin = accept;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue a single op, then check its result cycle
  task automatic one_op(input string tag, input bit jalr, input logic [3:0] ctrl,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic [31:0] pc);
    drive(1'b1, jalr, ctrl, rs1, rs2, imm, pc);
    step();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    check_all(tag);
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    model_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    check_all("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Directed cases
    one_op("beq",  1'b0, 4'b0011, 32'd5, 32'd5, 32'h20, 32'h100);
    one_op("blt",  1'b0, 4'b0110, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h200);
    one_op("bltu", 1'b0, 4'b1001, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h200);
    one_op("bge",  1'b0, 4'b1010, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h200);
    one_op("bgeu", 1'b0, 4'b1101, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h200);
    one_op("jalr", 1'b1, 4'b0000, 32'h1000, 32'h0, 32'hFFFF_FFFC, 32'h40);
    one_op("wrap", 1'b0, 4'b1110, 32'h0, 32'h0, 32'h4, 32'hFFFF_FFFC);
    one_op("none", 1'b0, 4'b0001, 32'd3, 32'd3, 32'h10, 32'h300);
    // Outputs must hold after finish drops
    check_all("hold");

    // Back-to-back: en held high with fresh operands each cycle
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 4'b0010, 32'd7, 32'd7 + k, 32'h10 * (k + 1), 32'h1000 + 32'h100 * k);
      step();
      check_all($sformatf("b2b%0d", k));
    end
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    check_all("b2b_end");

    // Reset right after an op is accepted
    drive(1'b1, 1'b1, 4'b1111, 32'h5000, 32'h0, 32'h8, 32'h600);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("rst_mid");
    @(negedge clk);
    check_all("rst_hold");
    // Release with en already high: first edge must accept
    rst = 1'b1;
    drive(1'b1, 1'b0, 4'b1111, 32'h0, 32'h0, 32'h40, 32'h700);
    step();
    check_all("rst_release");
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 7) == 0) a = {1'b1, a[30:0]};
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
            a, b, $urandom, $urandom);
      step();
      check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_jump_resolve_unit

`default_nettype wire
